// File: rtl/xfifo_flags_if.sv
// xfifo_flags_if: bus bundle for the xfifo_flags synchronous FIFO.
//   master : drives write data/requests, read request, thresholds, error clear;
//            observes read data, valid, flags, count and sticky errors.
//   slave  : the FIFO side of the same signals.
interface xfifo_flags_if #(
  parameter int unsigned DATA_BITS = 10,
  parameter int unsigned ADDR_BITS = 3
);
  logic [DATA_BITS-1:0] fifo_data_in;
  logic                 fifo_write;
  logic                 fifo_read;
  logic [ADDR_BITS:0]   high_limit;
  logic [ADDR_BITS:0]   low_limit;
  logic                 error_clear;
  logic [DATA_BITS-1:0] fifo_data_out;
  logic                 fifo_valid_out;
  logic                 fifo_full_out;
  logic                 fifo_empty_out;
  logic                 full_out;
  logic                 empty_out;
  logic [ADDR_BITS:0]   fifo_count_out;
  logic                 overflow_out;
  logic                 underflow_out;
  logic                 error_fifo_out;

  modport master (
    output fifo_data_in, fifo_write, fifo_read, high_limit, low_limit, error_clear,
    input  fifo_data_out, fifo_valid_out, fifo_full_out, fifo_empty_out,
           full_out, empty_out, fifo_count_out, overflow_out, underflow_out,
           error_fifo_out
  );

  modport slave (
    input  fifo_data_in, fifo_write, fifo_read, high_limit, low_limit, error_clear,
    output fifo_data_out, fifo_valid_out, fifo_full_out, fifo_empty_out,
           full_out, empty_out, fifo_count_out, overflow_out, underflow_out,
           error_fifo_out
  );
endinterface

// File: rtl/xfifo_flags.sv
// xfifo_flags: synchronous FIFO, 2**ADDR_BITS entries of DATA_BITS, with
// occupancy counter, programmable almost-full/almost-empty flags, sticky
// overflow/underflow errors and registered or first-word-fall-through read.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : xfifo_flags_if.slave (data, requests, thresholds, flags, count, errors)
module xfifo_flags #(
  parameter int unsigned DATA_BITS = 10,
  parameter int unsigned ADDR_BITS = 3,
  parameter bit          FWFT      = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  xfifo_flags_if.slave   bus
);
  localparam int unsigned      SIZE   = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] SIZE_C = (ADDR_BITS + 1)'(SIZE);

  logic [DATA_BITS-1:0] mem_q [SIZE];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 full, empty, rd_ok, wr_ok;

  always_comb begin
    full     = (count_q == SIZE_C);
    empty    = (count_q == '0);
    rd_ok    = bus.fifo_read && !empty;
    // At full, a simultaneous accepted read frees the slot the write needs.
    wr_ok    = bus.fifo_write && (!full || rd_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;

    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
      dout_d   = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_BITS + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_BITS + 1)'(1);
      default: count_d = count_q;
    endcase

    // A new error event in the same cycle as error_clear wins.
    if (bus.fifo_write && !wr_ok) ovf_d = 1'b1;
    else if (bus.error_clear)     ovf_d = 1'b0;
    else                          ovf_d = ovf_q;

    if (bus.fifo_read && !rd_ok)  unf_d = 1'b1;
    else if (bus.error_clear)     unf_d = 1'b0;
    else                          unf_d = unf_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not cleared by reset, but writes are blocked while it is low.
  always_ff @(posedge clk) begin
    if (reset && wr_ok) mem_q[wr_ptr_q] <= bus.fifo_data_in;
  end

  assign bus.full_out       = full;
  assign bus.empty_out      = empty;
  assign bus.fifo_count_out = count_q;
  assign bus.overflow_out   = ovf_q;
  assign bus.underflow_out  = unf_q;
  assign bus.error_fifo_out = ovf_q | unf_q;

  assign bus.fifo_full_out  = (bus.high_limit == '0 || bus.high_limit > SIZE_C)
                              ? full : (count_q >= bus.high_limit);
  assign bus.fifo_empty_out = (bus.low_limit == '0)
                              ? empty : (count_q <= bus.low_limit);

  // In FWFT mode the head word is shown directly; it is forced to zero while
  // empty so the output reads 0 after reset like the registered mode.
  assign bus.fifo_data_out  = FWFT ? (empty ? '0 : mem_q[rd_ptr_q]) : dout_q;
  assign bus.fifo_valid_out = FWFT ? !empty : valid_q;
endmodule
